// File: rtl/ltc2358_axil_regs.sv
// rtl/ltc2358_axil_regs.sv - AXI4-Lite slave with four RW and four RO 32-bit registers
//
// Purpose: register block for the LTC2358 front end. Word index = ADDR[4:2];
//   indices 0-3 are RW (byte-strobed), 4-7 are RO and return RO_IN0..RO_IN3.
//   Writes to RO indices answer SLVERR and change nothing.
// Ports:
//   ACLK, ARESET         - single clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*      - AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*         - AXI4-Lite read address / data channels
//   REG0_OUT..REG3_OUT   - live values of RW registers 0-3
//   RO_IN0..RO_IN3       - values returned when reading indices 4-7
//   WR_PULSE             - bit n high for one cycle after a commit to RW register n
module ltc2358_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG0_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG1_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG2_OUT,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   REG3_OUT,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   RO_IN0,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   RO_IN1,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   RO_IN2,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   RO_IN3,
  output logic [3:0]                      WR_PULSE
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HAVE_AW = 2'd1;
  localparam logic [1:0] ST_HAVE_W  = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]    wr_state;
  logic [2:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [DW-1:0] regs [4];
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic [2:0]    cm_idx;
  logic [DW-1:0] cm_data;
  logic [SW-1:0] cm_strb;
  logic [2:0]    ar_idx;
  logic [DW-1:0] rd_mux;

  // Readies are gated directly by ARESET so they are low while reset is held
  // and rise as soon as it is released.
  assign S_AXI_AWREADY = !ARESET && !bvalid_q && (wr_state == ST_IDLE || wr_state == ST_HAVE_W);
  assign S_AXI_WREADY  = !ARESET && !bvalid_q && (wr_state == ST_IDLE || wr_state == ST_HAVE_AW);
  assign S_AXI_ARREADY = !ARESET && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit as soon as both halves are present, taking each half either from
  // its latch or straight from the bus when it arrives this cycle.
  assign commit  = (aw_hs || wr_state == ST_HAVE_AW) && (w_hs || wr_state == ST_HAVE_W);
  assign cm_idx  = aw_hs ? S_AXI_AWADDR[4:2] : aw_idx_q;
  assign cm_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign cm_strb = w_hs ? S_AXI_WSTRB : wstrb_q;

  assign ar_idx = S_AXI_ARADDR[4:2];

  always_comb begin
    rd_mux = '0;
    if (!ar_idx[2]) begin
      rd_mux = regs[ar_idx[1:0]];
    end else begin
      case (ar_idx[1:0])
        2'd0:    rd_mux = RO_IN0;
        2'd1:    rd_mux = RO_IN1;
        2'd2:    rd_mux = RO_IN2;
        default: rd_mux = RO_IN3;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state <= ST_IDLE;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      WR_PULSE <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      WR_PULSE <= '0;
      case (wr_state)
        ST_IDLE, ST_HAVE_AW, ST_HAVE_W: begin
          if (commit) begin
            wr_state <= ST_RESP;
            bvalid_q <= 1'b1;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            if (!cm_idx[2]) begin
              for (int k = 0; k < SW; k++) begin
                if (cm_strb[k]) regs[cm_idx[1:0]][8*k +: 8] <= cm_data[8*k +: 8];
              end
              // Pulse even for an all-zero strobe: the write still happened.
              WR_PULSE <= 4'b0001 << cm_idx[1:0];
              bresp_q  <= RESP_OKAY;
            end else begin
              bresp_q  <= RESP_SLVERR;
            end
          end else if (aw_hs) begin
            wr_state <= ST_HAVE_AW;
            aw_idx_q <= S_AXI_AWADDR[4:2];
          end else if (w_hs) begin
            wr_state <= ST_HAVE_W;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
          end
        end
        default: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            wr_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Read path: RDATA is captured at the AR handshake, so a write committing
  // in the same cycle is not visible until the next read.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = RESP_OKAY;

  assign REG0_OUT = regs[0];
  assign REG1_OUT = regs[1];
  assign REG2_OUT = regs[2];
  assign REG3_OUT = regs[3];

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: doc/ltc2358_axil_regs.md
LTC2358_AXIL_REGS -- requirements
Module: ltc2358_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 registers x 4 bytes).
REQ-003 SHALL have ports: ACLK in 1, single clock; ARESET in 1, reset, synchronous, active-high.
REQ-004 SHALL have AW channel: S_AXI_AWADDR in 5; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-005 SHALL have W channel: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-006 SHALL have B channel: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-007 SHALL have AR channel: S_AXI_ARADDR in 5; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-008 SHALL have R channel: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-009 SHALL have REG0_OUT..REG3_OUT out 32 each: current values of RW registers 0-3.
REQ-010 SHALL have RO_IN0..RO_IN3 in 32 each: values returned for RO registers 4-7.
REQ-011 SHALL have WR_PULSE out 4: bit n high one cycle when RW register n is written.

Function
REQ-012 Register map SHALL be: word index = ADDR[4:2]; 0-3 RW; 4-7 RO; ADDR[1:0] ignored.
REQ-013 AW and W SHALL be accepted independently: AWREADY high iff no AW latched and BVALID low; WREADY high iff no W latched and BVALID low.
REQ-014 Accepted AWADDR, WDATA, WSTRB SHALL be held in latches until the write commits.
REQ-015 Write SHALL commit in the first cycle both AW and W are latched (same-cycle acceptance of both allowed); latches cleared at commit.
REQ-016 On commit to index 0-3, byte k of register SHALL update iff WSTRB[k]=1; BRESP=2'b00 (OKAY).
REQ-017 On commit to index 4-7, no register SHALL change, WR_PULSE SHALL stay 0, and BRESP=2'b10 (SLVERR).
REQ-018 BVALID SHALL assert the cycle after commit and hold, with BRESP stable, until BVALID&&BREADY; then deassert next cycle.
REQ-019 WR_PULSE[n] SHALL assert in the cycle after commit to index n (coincident with BVALID rise), including WSTRB=0 writes.
REQ-020 Write FSM states: IDLE (nothing latched), HAVE_AW, HAVE_W, RESP; IDLE->HAVE_AW/HAVE_W on single acceptance, ->RESP on commit, RESP->IDLE on B handshake.
REQ-021 ARREADY SHALL be high iff RVALID low and no read pending; one read outstanding at most.
REQ-022 On AR handshake, RVALID SHALL assert next cycle with RDATA = register[index] (RW: stored value; RO: RO_IN sampled at AR handshake), RRESP=2'b00.
REQ-023 RVALID, RDATA, RRESP SHALL hold stable until RVALID&&RREADY; RVALID low next cycle, ARREADY high that same cycle.
REQ-024 Read and write channels SHALL operate concurrently; a read in the cycle of a commit to the same index SHALL return the pre-write value.
REQ-025 Back-to-back reads SHALL sustain one transfer per 2 cycles with RREADY tied high; back-to-back writes one per 2 cycles with BREADY tied high.
REQ-026 VALID held without READY SHALL never cause duplicate acceptance; the block SHALL not depend on master VALID deassertion timing.

Reset
REQ-027 While ARESET=1 at an ACLK edge: REG0..REG3=0, latches cleared, FSMs to IDLE, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, WR_PULSE=0.
REQ-028 During reset AWREADY=WREADY=ARREADY=0; they SHALL assert the first cycle after ARESET falls.
REQ-029 Reset mid-transaction SHALL abandon it with no register update and no B/R response after reset.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, WSTRB=0xF -> BRESP OKAY each; read back 0x1..0x4; REG0_OUT..REG3_OUT match; WR_PULSE bits 0..3 each pulse once.
REQ-031 REG1=0xFFFFFFFF, write 0x00000000 to 0x04 with WSTRB=0x5 -> REG1_OUT=0xFF00FF00.
REQ-032 W presented 3 cycles before AW, then AW 3 cycles before W -> each commits once, BVALID one cycle after later handshake.
REQ-033 Write 0xDEAD to 0x10 -> BRESP=2'b10, all REG*_OUT unchanged, WR_PULSE=0; RO_IN0=0xCAFE0000, read 0x10 -> RDATA 0xCAFE0000 OKAY.
REQ-034 BREADY/RREADY held low 10 cycles -> BVALID/RVALID, BRESP/RDATA stable throughout; AWREADY, WREADY, ARREADY low throughout.
REQ-035 ARESET pulsed with AW latched, W pending -> after reset no BVALID, REG0..REG3=0, ready signals high next cycle.
